rgb_color_sequencer: RTL and testbench
======================================

# rgb_color_sequencer

Parametrised RGB colour selector for the joystick LED path. It takes two raw push-buttons (next and previous), synchronises and debounces them, and steps a wrapping palette index. The index selects one of NUM_COLORS preset colours, and the block drives the packed RGB word consumed by the LED PWM stage. A compile-time option replaces the instant colour jump with a timed linear fade.

## Interface
Parameters:
- CW, 8: bits per colour channel (4..12).
- NUM_COLORS, 4: number of palette entries used (2..8).
- DEBOUNCE_CYCLES, 12000: stable-input cycles before a button level is accepted (1 ms at 12 MHz).
- FADE_DIV, 256: clocks per fade step. Must be ≥ 1. Only used with COLOR_FADE_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- button  in  2  raw asynchronous buttons; [0] = next, [1] = previous.
- RGBcolor  out  3*CW  packed {red, green, blue}.
- color_idx  out  3  current palette index; bits above clog2(NUM_COLORS) are 0.
- busy  out  1  high while RGBcolor differs from the target colour.

## Operation
- Reset values: color_idx = 0, RGBcolor = palette[0], busy = 0. All debounce state is cleared, with each accepted button level = 0.
- Half-scale value H = {1'b0, {CW-1{1'b1}}}, i.e. 0x7F at CW = 8.
- Palette order (first NUM_COLORS entries used): 0 white (H,H,H), 1 red (H,0,0), 2 green (0,H,0), 3 blue (0,0,H), 4 yellow (H,H,0), 5 cyan (0,H,H), 6 magenta (H,0,H), 7 off (0,0,0).
- Each button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer counter resets whenever the synchronised input equals the accepted level.
  - The accepted level toggles when the counter reaches DEBOUNCE_CYCLES-1.
  - A 0→1 toggle of the accepted level emits a one-cycle step pulse.
- Index update on the clock after a pulse:
  - next only: idx+1, wrapping NUM_COLORS-1 → 0.
  - prev only: idx-1, wrapping 0 → NUM_COLORS-1.
  - both in the same cycle: no change.
- Holding a button gives exactly one step. Release and re-press are required for the next step.
- The target colour is palette[color_idx], decoded combinationally.

## Timing
- Button held high from cycle 0 (stable): color_idx changes on edge DEBOUNCE_CYCLES+3.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no step.
- Without fade: RGBcolor equals the target one clock after color_idx changes, and busy stays 0.
- With fade (see Configuration):
  - Prescaler counts 0..FADE_DIV-1 while busy and is held at 0 while not busy.
  - On each prescaler wrap, every channel moves by exactly 1 toward its target. A channel already at its target holds.
  - busy rises one clock after color_idx changes to a colour different from RGBcolor.
  - busy falls on the clock on which the last channel reaches its target.
  - Fade duration = max channel distance × FADE_DIV clocks.
- Index change mid-fade: the target switches immediately. Channels continue from their current values and the prescaler is not cleared.
- Reset asserted mid-fade: all outputs return to reset values asynchronously.
- Channel arithmetic is unsigned CW-bit. Steps never overshoot or wrap.

## Configuration
- COLOR_FADE_EN defined: fade engine present, with prescaler, per-channel up/down steppers and busy as specified above.
- COLOR_FADE_EN undefined: RGBcolor is a register loaded with the target every clock, busy is tied 0, and FADE_DIV is ignored.

## Structure
- Package rgb_color_pkg holds:
  - palette index constants (IDX_WHITE … IDX_OFF);
  - a palette lookup function (idx, CW) → 3*CW word built from H;
  - MAX_COLORS = 8.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, din, level, rise_pulse), instantiated twice.
- The top level holds the index counter, target decode and the fade engine.

## Test plan
Bench parameters: CW = 8, NUM_COLORS = 4, DEBOUNCE_CYCLES = 4, FADE_DIV = 2.
- Reset release → RGBcolor = 0x7F7F7F, color_idx = 0, busy = 0.
- button[0] held 10 cycles, no fade → color_idx = 1 on edge 7, RGBcolor = 0x7F0000 on edge 8. Holding longer causes no further step.
- Four next presses from idx 3 → wraps through 0; one prev press at idx 0 → idx 3, RGBcolor = 0x00007F.
- A 3-cycle pulse on button[0], then a pulse on both buttons accepted in the same cycle → color_idx unchanged in both cases.
- COLOR_FADE_EN, white → red:
  - busy high for 254 clocks.
  - Green and blue decrement by 1 every 2 clocks.
  - Final RGBcolor = 0x7F0000.
- COLOR_FADE_EN, next pressed again mid-fade when green = 0x40 → target becomes green:
  - Green rises from 0x40 and red falls without a jump.
  - Ends at 0x007F00.
  - Asserting rst_n low mid-fade restores 0x7F7F7F immediately.

Source files
------------

// File: rtl/rgb_color_pkg.sv
// Shared constants and palette decode for the RGB colour sequencer.
// Contents: palette index constants, MAX_COLORS, and palette_lookup(idx, cw),
// which returns a {red, green, blue} word of 3*cw bits (right-aligned in a
// 3*CW_MAX container) built from the half-scale value H = {1'b0, {cw-1{1'b1}}}.
package rgb_color_pkg;

  localparam int unsigned MAX_COLORS = 8;
  localparam int unsigned CW_MAX     = 12;
  localparam int unsigned IDX_W      = 3;

  localparam logic [IDX_W-1:0] IDX_WHITE   = 3'd0;
  localparam logic [IDX_W-1:0] IDX_RED     = 3'd1;
  localparam logic [IDX_W-1:0] IDX_GREEN   = 3'd2;
  localparam logic [IDX_W-1:0] IDX_BLUE    = 3'd3;
  localparam logic [IDX_W-1:0] IDX_YELLOW  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_CYAN    = 3'd5;
  localparam logic [IDX_W-1:0] IDX_MAGENTA = 3'd6;
  localparam logic [IDX_W-1:0] IDX_OFF     = 3'd7;

  // Each palette entry is a per-channel on/off mask; "on" channels carry H.
  function automatic logic [3*CW_MAX-1:0] palette_lookup(input logic [IDX_W-1:0] idx,
                                                         input int unsigned cw);
    logic [CW_MAX-1:0]   h;
    logic [2:0]          mask;
    logic [3*CW_MAX-1:0] word;
    h = CW_MAX'((32'd1 << (cw - 32'd1)) - 32'd1);
    case (idx)
      IDX_WHITE:   mask = 3'b111;
      IDX_RED:     mask = 3'b100;
      IDX_GREEN:   mask = 3'b010;
      IDX_BLUE:    mask = 3'b001;
      IDX_YELLOW:  mask = 3'b110;
      IDX_CYAN:    mask = 3'b011;
      IDX_MAGENTA: mask = 3'b101;
      IDX_OFF:     mask = 3'b000;
      default:     mask = 3'b000;
    endcase
    word = '0;
    if (mask[2]) word = word | ((3*CW_MAX)'(h) << (2 * cw));
    if (mask[1]) word = word | ((3*CW_MAX)'(h) << cw);
    if (mask[0]) word = word | (3*CW_MAX)'(h);
    return word;
  endfunction

endpackage

// File: rtl/rgb_color_sequencer_debounce.sv
// Two-flop synchroniser plus level debouncer for one raw push-button.
// Ports: clk, rst_n (async active-low), din (raw button), level (accepted,
// debounced level), rise_pulse (one-cycle pulse on an accepted 0->1 change).
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             din_s;

  assign din_s = sync_q[1];

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], din};
      rise_pulse <= 1'b0;
      if (din_s == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q      <= '0;
        level      <= din_s;
        rise_pulse <= din_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_color_sequencer.sv
// Button-driven palette stepper for the joystick LED path.
// Ports: clk, rst_n (async active-low), button[1:0] ([0] next, [1] previous),
// RGBcolor (packed {red, green, blue}, CW bits each), color_idx (palette index),
// busy (RGBcolor still moving toward the target colour).
// Build option: define COLOR_FADE_EN for a timed linear fade between colours;
// otherwise RGBcolor follows the target one clock later and busy stays 0.
module rgb_color_sequencer
  import rgb_color_pkg::*;
#(
  parameter int unsigned CW              = 8,
  parameter int unsigned NUM_COLORS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned FADE_DIV        = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      button,
  output logic [3*CW-1:0] RGBcolor,
  output logic [2:0]      color_idx,
  output logic            busy
);

  localparam logic [2:0]      IDX_LAST  = 3'(NUM_COLORS - 1);
  localparam logic [3*CW-1:0] RESET_RGB = (3*CW)'(palette_lookup(IDX_WHITE, CW));

  logic       next_pulse;
  logic       prev_pulse;
  logic [1:0] unused_level;
  logic [3*CW-1:0] target_c;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (button[0]),
    .level      (unused_level[0]),
    .rise_pulse (next_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (button[1]),
    .level      (unused_level[1]),
    .rise_pulse (prev_pulse)
  );

  // Wrapping index; simultaneous next and previous cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_idx <= '0;
    end else if (next_pulse && !prev_pulse) begin
      color_idx <= (color_idx == IDX_LAST) ? 3'd0 : color_idx + 3'd1;
    end else if (prev_pulse && !next_pulse) begin
      color_idx <= (color_idx == 3'd0) ? IDX_LAST : color_idx - 3'd1;
    end
  end

  assign target_c = (3*CW)'(palette_lookup(color_idx, CW));

`ifdef COLOR_FADE_EN
  localparam int unsigned PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(FADE_DIV - 1);

  logic [PW-1:0]   presc_q;
  logic            step_c;
  logic [3*CW-1:0] rgb_nxt_c;

  // One unit toward the target, never past it.
  function automatic logic [CW-1:0] step_channel(input logic [CW-1:0] cur,
                                                 input logic [CW-1:0] tgt,
                                                 input logic          en);
    if (!en || cur == tgt) return cur;
    else if (cur < tgt)    return cur + CW'(1);
    else                   return cur - CW'(1);
  endfunction

  assign step_c = busy && (presc_q == PRESC_LAST);

  always_comb begin
    rgb_nxt_c = RGBcolor;
    for (int c = 0; c < 3; c++) begin
      rgb_nxt_c[c*CW +: CW] = step_channel(RGBcolor[c*CW +: CW], target_c[c*CW +: CW], step_c);
    end
  end

  // busy compares the post-step colour, so it drops on the edge of the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RGBcolor <= RESET_RGB;
      presc_q  <= '0;
      busy     <= 1'b0;
    end else begin
      RGBcolor <= rgb_nxt_c;
      busy     <= (rgb_nxt_c != target_c);
      if (!busy || presc_q == PRESC_LAST) presc_q <= '0;
      else                                presc_q <= presc_q + PW'(1);
    end
  end
`else
  // FADE_DIV has no effect without the fade engine.
  localparam int unsigned unused_fade_div = FADE_DIV;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) RGBcolor <= RESET_RGB;
    else        RGBcolor <= target_c;
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Self-checking bench for rgb_color_sequencer (CW=8, NUM_COLORS=4,
// DEBOUNCE_CYCLES=4, FADE_DIV=2). Define COLOR_FADE_EN for the fade build.
module tb_rgb_color_sequencer;

  localparam int unsigned CW = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned FD = 2;
`ifdef COLOR_FADE_EN
  localparam int SETTLE = 300;
`else
  localparam int SETTLE = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    button;
  logic [23:0]   rgb;
  logic [2:0]    idx;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  btn;
    int          hold;
    logic [2:0]  idx;
    logic [23:0] rgb;
    string       name;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  rgb_color_sequencer #(
    .CW(CW), .NUM_COLORS(NC), .DEBOUNCE_CYCLES(DB), .FADE_DIV(FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .RGBcolor  (rgb),
    .color_idx (idx),
    .busy      (busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] b, input int hold);
    button = b;
    tick(hold);
    button = 2'b00;
    tick(SETTLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int slope_bad;
    int jumps;
    logic [7:0]  exp_ch;
    logic [23:0] prev_rgb;
    logic        switched;

    tbl[0]  = '{2'b01, 8, 3'd2, 24'h007F00, "next_1_2"};
    tbl[1]  = '{2'b01, 8, 3'd3, 24'h00007F, "next_2_3"};
    tbl[2]  = '{2'b01, 8, 3'd0, 24'h7F7F7F, "next_wrap_3_0"};
    tbl[3]  = '{2'b01, 8, 3'd1, 24'h7F0000, "next_0_1"};
    tbl[4]  = '{2'b01, 8, 3'd2, 24'h007F00, "next_1_2b"};
    tbl[5]  = '{2'b01, 8, 3'd3, 24'h00007F, "next_2_3b"};
    tbl[6]  = '{2'b01, 8, 3'd0, 24'h7F7F7F, "next_wrap_again"};
    tbl[7]  = '{2'b10, 8, 3'd3, 24'h00007F, "prev_wrap_0_3"};
    tbl[8]  = '{2'b10, 8, 3'd2, 24'h007F00, "prev_3_2"};
    tbl[9]  = '{2'b01, 3, 3'd2, 24'h007F00, "glitch_3cyc"};
    tbl[10] = '{2'b11, 8, 3'd2, 24'h007F00, "both_buttons"};
    tbl[11] = '{2'b10, 8, 3'd1, 24'h7F0000, "prev_2_1"};

    rst_n  = 1'b0;
    button = 2'b00;
    tick(3);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'h7F7F7F);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("rel_idx", 32'(idx), 32'd0);
    chk("rel_rgb", 32'(rgb), 32'h7F7F7F);

    // First step latency: button goes high right after edge 0.
    button = 2'b01;
`ifndef COLOR_FADE_EN
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e == 6) chk("lat_idx_e6", 32'(idx), 32'd0);
      if (e == 7) begin
        chk("lat_idx_e7", 32'(idx), 32'd1);
        chk("lat_rgb_e7", 32'(rgb), 32'h7F7F7F);
      end
      if (e == 8) begin
        chk("lat_rgb_e8", 32'(rgb), 32'h7F0000);
        chk("lat_busy_e8", 32'(busy), 32'd0);
      end
    end
    tick(10);
    chk("hold_one_step", 32'(idx), 32'd1);
`else
    busy_cnt  = 0;
    slope_bad = 0;
    for (int e = 1; e <= 600; e++) begin
      tick(1);
      if (e == 6) chk("lat_idx_e6", 32'(idx), 32'd0);
      if (e == 7) begin
        chk("lat_idx_e7", 32'(idx), 32'd1);
        chk("busy_low_e7", 32'(busy), 32'd0);
      end
      if (e == 8) chk("busy_rise_e8", 32'(busy), 32'd1);
      if (e >= 8) begin
        if (busy) busy_cnt++;
        exp_ch = 8'h7F - 8'((e - 8) / 2);
        if (rgb !== {8'h7F, exp_ch, exp_ch}) slope_bad++;
        if (!busy) break;
      end
    end
    chk("fade_busy_len", 32'(busy_cnt), 32'd254);
    chk("fade_slope", 32'(slope_bad), 32'd0);
    chk("fade_final_rgb", 32'(rgb), 32'h7F0000);
    chk("hold_one_step", 32'(idx), 32'd1);
`endif
    button = 2'b00;
    tick(SETTLE);

    foreach (tbl[i]) begin
      press(tbl[i].btn, tbl[i].hold);
      chk({tbl[i].name, "_idx"}, 32'(idx), 32'(tbl[i].idx));
      chk({tbl[i].name, "_rgb"}, 32'(rgb), 32'(tbl[i].rgb));
      chk({tbl[i].name, "_busy"}, 32'(busy), 32'd0);
    end

`ifdef COLOR_FADE_EN
    // Retarget mid-fade: white -> red, then green once G reaches 0x40.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("re_rst_rgb", 32'(rgb), 32'h7F7F7F);
    button = 2'b01;
    tick(8);
    button = 2'b00;
    for (int i = 0; i < 400 && rgb[15:8] != 8'h40; i++) tick(1);
    chk("green_at_40", 32'(rgb[15:8]), 32'h40);

    button   = 2'b01;
    switched = 1'b0;
    jumps    = 0;
    prev_rgb = rgb;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (i == 8) button = 2'b00;
      if (switched) begin
        if (!(prev_rgb[23:16] - rgb[23:16] inside {8'd0, 8'd1})) jumps++;
        if (!(rgb[15:8] - prev_rgb[15:8] inside {8'd0, 8'd1})) jumps++;
        if (!(prev_rgb[7:0] - rgb[7:0] inside {8'd0, 8'd1})) jumps++;
        if (!busy) break;
      end else if (idx == 3'd2) begin
        switched = 1'b1;
        chk("switch_green_le40", 32'(rgb[15:8] <= 8'h40), 32'd1);
        chk("switch_green_ge3b", 32'(rgb[15:8] >= 8'h3B), 32'd1);
        chk("switch_red_7f", 32'(rgb[23:16]), 32'h7F);
      end
      prev_rgb = rgb;
    end
    button = 2'b00;
    chk("retarget_seen", 32'(switched), 32'd1);
    chk("retarget_no_jump", 32'(jumps), 32'd0);
    chk("retarget_final", 32'(rgb), 32'h007F00);
    chk("retarget_busy", 32'(busy), 32'd0);

    // Reset in the middle of a green -> blue fade.
    button = 2'b01;
    tick(8);
    button = 2'b00;
    tick(20);
    chk("midfade_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb), 32'h7F7F7F);
    chk("async_rst_idx", 32'(idx), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
